// File: rtl/scan_pkg.sv
// Shared types and constants for the padded convolution scan scheduler.
package scan_pkg;

    localparam int unsigned COORD_W   = 15;
    localparam int unsigned IMG_W_DEF = 640;
    localparam int unsigned IMG_H_DEF = 640;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Map a padded index 0..n+1 onto the unpadded range 0..n-1 (border replicates the edge).
    function automatic logic [COORD_W-1:0] clamp_idx(input logic [COORD_W-1:0] p,
                                                      input int unsigned       n);
        if (p == '0) begin
            return '0;
        end else if (p == COORD_W'(n + 1)) begin
            return COORD_W'(n - 1);
        end else begin
            return p - COORD_W'(1);
        end
    endfunction

endpackage

// File: rtl/pad_axis_counter.sv
// One axis of the padded scan: index 0..N+1 with first/last decode and clamped coordinate.
module pad_axis_counter
    import scan_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic               last_c,
    output logic               first_nxt_c,
    output logic               last_nxt_c,
    output logic [COORD_W-1:0] clamp_nxt_c
);

    localparam logic [COORD_W-1:0] LAST_IDX = COORD_W'(N + 1);

    logic [COORD_W-1:0] idx_q;
    logic [COORD_W-1:0] idx_d;

    // Next index: clear wins, increment wraps after the trailing pad position.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + COORD_W'(1);
        end
    end

    // Index register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign last_c      = (idx_q == LAST_IDX);
    assign first_nxt_c = (idx_d == '0);
    assign last_nxt_c  = (idx_d == LAST_IDX);
    assign clamp_nxt_c = clamp_idx(idx_d, N);

endmodule

// File: rtl/conv_scan_scheduler.sv
// Raster scheduler for a 1-pixel padded frame; every output is a flop.
// Optional feature: define SCAN_ABORT_EN to add the abort input.
module conv_scan_scheduler
    import scan_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef SCAN_ABORT_EN
    input  logic               abort,
`endif
    input  logic               out_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               pad_left,
    output logic               pad_right,
    output logic               pad_top,
    output logic               pad_bottom,
    output logic               row_start,
    output logic               busy,
    output logic               done
);

    state_e state_q, state_d;

    logic               col_inc_c, row_inc_c, clr_c;
    logic               col_last_c, row_last_c;
    logic               col_first_nxt_c, col_last_nxt_c, row_first_nxt_c, row_last_nxt_c;
    logic [COORD_W-1:0] col_nxt_c, row_nxt_c;

    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic               pad_left_q, pad_left_d, pad_right_q, pad_right_d;
    logic               pad_top_q, pad_top_d, pad_bottom_q, pad_bottom_d;
    logic               row_start_q, row_start_d, busy_q, busy_d, done_q, done_d;

    pad_axis_counter #(.N(IMG_W)) u_col_cnt (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr_c),
        .inc         (col_inc_c),
        .last_c      (col_last_c),
        .first_nxt_c (col_first_nxt_c),
        .last_nxt_c  (col_last_nxt_c),
        .clamp_nxt_c (col_nxt_c)
    );

    pad_axis_counter #(.N(IMG_H)) u_row_cnt (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr_c),
        .inc         (row_inc_c),
        .last_c      (row_last_c),
        .first_nxt_c (row_first_nxt_c),
        .last_nxt_c  (row_last_nxt_c),
        .clamp_nxt_c (row_nxt_c)
    );

    // State transitions and counter control; a beat is accepted only while scanning with out_ready.
    always_comb begin
        logic accept;
        state_d   = state_q;
        accept    = (state_q == ST_SCAN) && out_ready;
        col_inc_c = accept;
        row_inc_c = accept && col_last_c && !row_last_c;
        clr_c     = accept && col_last_c && row_last_c;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_GAP;
            ST_GAP:  state_d = ST_SCAN;
            ST_SCAN: if (accept && col_last_c) state_d = row_last_c ? ST_DONE : ST_GAP;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef SCAN_ABORT_EN
        if (abort && (state_q == ST_GAP || state_q == ST_SCAN)) begin
            state_d   = ST_IDLE;
            col_inc_c = 1'b0;
            row_inc_c = 1'b0;
            clr_c     = 1'b1;
        end
`endif
    end

    // Output flop inputs decoded from next state and next counter values.
    always_comb begin
        pix_valid_d  = (state_d == ST_SCAN);
        row_start_d  = (state_d == ST_GAP);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        col_d        = col_nxt_c;
        row_d        = row_nxt_c;
        pad_left_d   = pix_valid_d && col_first_nxt_c;
        pad_right_d  = pix_valid_d && col_last_nxt_c;
        pad_top_d    = pix_valid_d && row_first_nxt_c;
        pad_bottom_d = pix_valid_d && row_last_nxt_c;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pix_valid_q  <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            pad_left_q   <= 1'b0;
            pad_right_q  <= 1'b0;
            pad_top_q    <= 1'b0;
            pad_bottom_q <= 1'b0;
            row_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_valid_q  <= pix_valid_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pad_left_q   <= pad_left_d;
            pad_right_q  <= pad_right_d;
            pad_top_q    <= pad_top_d;
            pad_bottom_q <= pad_bottom_d;
            row_start_q  <= row_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign pad_left   = pad_left_q;
    assign pad_right  = pad_right_q;
    assign pad_top    = pad_top_q;
    assign pad_bottom = pad_bottom_q;
    assign row_start  = row_start_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conv_scan_scheduler.sv
// Self-checking bench for conv_scan_scheduler on a 4x3 image.
module tb_conv_scan_scheduler;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int PW    = W + 2;
    localparam int PH    = H + 2;
    localparam int TOTAL = PW * PH;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;
`ifdef SCAN_ABORT_EN
    logic        abort;
`endif
    logic        pix_valid;
    logic [14:0] col;
    logic [14:0] row;
    logic        pad_left, pad_right, pad_top, pad_bottom;
    logic        row_start, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    conv_scan_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
`ifdef SCAN_ABORT_EN
        .abort      (abort),
`endif
        .out_ready  (out_ready),
        .pix_valid  (pix_valid),
        .col        (col),
        .row        (row),
        .pad_left   (pad_left),
        .pad_right  (pad_right),
        .pad_top    (pad_top),
        .pad_bottom (pad_bottom),
        .row_start  (row_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_coord(input int p, input int n);
        if (p == 0) return 0;
        if (p == n + 1) return n - 1;
        return p - 1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
        chk({tag, "_row_start"}, 32'(row_start), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Start a frame and follow it beat by beat against a position-list model.
    // mode 0: ready always, 1: random ready, 2: 5-cycle stall at pc=2,pr=1, 3: ready always + random start.
    // Returns early (still scanning) when beat stop_beat is on the outputs.
    task automatic run_scan(input int mode, input int stop_beat,
                            output int beats, output int rs, output int done_cyc);
        int  k     = 0;
        int  cyc   = 1;
        int  stall = 0;
        bit  gap   = 1'b1;
        bit  dn    = 1'b0;
        bit  fin   = 1'b0;
        bit  rdy;
        int  pc, pr;
        beats    = 0;
        rs       = 0;
        done_cyc = -1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        while (cyc < 2000 && !fin) begin
            if (stop_beat >= 0 && !gap && !dn && k == stop_beat) return;
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && k == 8 && stall < 5) rdy = 1'b0;
            if (mode == 3) start = 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (dn) begin
                start = 1'b0;
                chk("done_pulse", 32'(done), 1);
                chk("done_busy", 32'(busy), 1);
                chk("done_pix_valid", 32'(pix_valid), 0);
                done_cyc = cyc;
                fin      = 1'b1;
            end else if (gap) begin
                chk("gap_row_start", 32'(row_start), 1);
                chk("gap_pix_valid", 32'(pix_valid), 0);
                chk("gap_busy", 32'(busy), 1);
                chk("gap_done", 32'(done), 0);
                rs++;
                gap = 1'b0;
            end else begin
                pc = k % PW;
                pr = k / PW;
                chk("scan_pix_valid", 32'(pix_valid), 1);
                chk("scan_row_start", 32'(row_start), 0);
                chk("scan_col", 32'(col), 32'(exp_coord(pc, W)));
                chk("scan_row", 32'(row), 32'(exp_coord(pr, H)));
                chk("scan_pad_left", 32'(pad_left), 32'(pc == 0));
                chk("scan_pad_right", 32'(pad_right), 32'(pc == PW - 1));
                chk("scan_pad_top", 32'(pad_top), 32'(pr == 0));
                chk("scan_pad_bottom", 32'(pad_bottom), 32'(pr == PH - 1));
                chk("scan_busy", 32'(busy), 1);
                if (mode == 2 && k == 8 && !rdy) begin
                    stall++;
                    chk("stall_col_held", 32'(col), 1);
                    chk("stall_row_held", 32'(row), 0);
                end
                if (mode == 2 && k == 9) chk("stall_advance_col", 32'(col), 2);
                if (rdy) begin
                    k++;
                    beats++;
                    if (k % PW == 0) begin
                        if (k == TOTAL) dn = 1'b1;
                        else gap = 1'b1;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!fin) chk("scan_timeout", 0, 1);
        else chk_idle("after_done");
    endtask

    initial begin
        int beats, rs, dcyc;
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
`ifdef SCAN_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_col", 32'(col), 0);
        chk("reset_row", 32'(row), 0);
        chk("reset_pads", 32'({pad_left, pad_right, pad_top, pad_bottom}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("idle_no_start");

        // Full frame with out_ready held high.
        run_scan(0, -1, beats, rs, dcyc);
        chk("full_beats", 32'(beats), 32'(TOTAL));
        chk("full_row_starts", 32'(rs), 32'(PH));
        chk("full_done_latency", 32'(dcyc), 32'(TOTAL + PH + 1));

        // Stall at pc=2, pr=1.
        run_scan(2, -1, beats, rs, dcyc);
        chk("stall_beats", 32'(beats), 32'(TOTAL));

        // Random backpressure, two frames.
        for (int f = 0; f < 2; f++) begin
            run_scan(1, -1, beats, rs, dcyc);
            chk("rand_beats", 32'(beats), 32'(TOTAL));
            chk("rand_row_starts", 32'(rs), 32'(PH));
        end

        // start toggled while scanning is ignored.
        run_scan(3, -1, beats, rs, dcyc);
        chk("start_ignored_beats", 32'(beats), 32'(TOTAL));
        repeat (2) @(negedge clk);
        chk_idle("start_ignored_idle");

        // Reset mid-scan at beat 12, then a fresh start.
        run_scan(0, 12, beats, rs, dcyc);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_idle("midreset");
        chk("midreset_col", 32'(col), 0);
        chk("midreset_row", 32'(row), 0);
        repeat (3) @(negedge clk);
        chk_idle("midreset_needs_start");
        run_scan(0, -1, beats, rs, dcyc);
        chk("restart_beats", 32'(beats), 32'(TOTAL));
        chk("restart_latency", 32'(dcyc), 32'(TOTAL + PH + 1));

`ifdef SCAN_ABORT_EN
        // Abort at beat 7: straight to idle, no done.
        run_scan(0, 7, beats, rs, dcyc);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort");
        chk("abort_col", 32'(col), 0);
        repeat (3) @(negedge clk);
        chk_idle("abort_later");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_in_idle");
        run_scan(0, -1, beats, rs, dcyc);
        chk("post_abort_beats", 32'(beats), 32'(TOTAL));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
